// File: rtl/spi_link_pkg.sv
// Shared definitions for the 4-wire serial link (CLK/DATA/LOAD/STOP), used by both transmit and receive sides.
// Optional feature: SPI_SENDER_PARITY_EN adds an odd-parity bit after bit0 of every word.
package spi_link_pkg;

  localparam int WORD_W    = 16;
  // Wide enough to index a word plus its optional parity bit.
  localparam int BIT_CNT_W = $clog2(WORD_W + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    SHIFT = 3'd3,
    GAP   = 3'd4,
    STOP  = 3'd5
  } link_state_e;

`ifdef SPI_SENDER_PARITY_EN
  function automatic logic odd_parity(input logic [WORD_W-1:0] word);
    return ~(^word);
  endfunction
`endif

endpackage

// File: rtl/spi_sender_fifo.sv
// Show-ahead synchronous word FIFO, depth 2**AW, with registered full/empty flags.
// Pointers carry one extra wrap bit; full/empty are decided on that MSB.
module spi_sender_fifo #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_r [DEPTH];
  logic [AW:0]   wr_ptr_r, rd_ptr_r;
  logic [AW:0]   wr_ptr_nx_s, rd_ptr_nx_s;
  logic          push_s, pop_s;
  logic          full_r, empty_r;

  // Qualify requests against the current flags and form next pointers.
  always_comb begin
    push_s      = wr_en && !full_r;
    pop_s       = rd_en && !empty_r;
    wr_ptr_nx_s = wr_ptr_r + {{AW{1'b0}}, push_s};
    rd_ptr_nx_s = rd_ptr_r + {{AW{1'b0}}, pop_s};
  end

  // Pointer and flag registers; flags are computed from next pointers so they stay registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      wr_ptr_r <= wr_ptr_nx_s;
      rd_ptr_r <= rd_ptr_nx_s;
      full_r   <= (wr_ptr_nx_s[AW] != rd_ptr_nx_s[AW]) &&
                  (wr_ptr_nx_s[AW-1:0] == rd_ptr_nx_s[AW-1:0]);
      empty_r  <= (wr_ptr_nx_s == rd_ptr_nx_s);
    end
  end

  // Storage write; contents are not reset, only the pointers.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_ptr_r[AW-1:0]];
  assign full    = full_r;
  assign empty   = empty_r;

endmodule

// File: rtl/spi_msg_sender.sv
// Buffers words and serializes one MSG_LEN-word message per START onto TX_CLK/TX_DATA/TX_LOAD/TX_STOP.
// Optional feature: SPI_SENDER_PARITY_EN appends an odd-parity bit to each word.
module spi_msg_sender
  import spi_link_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int FIFO_AW = 8,
  parameter int WORD_W  = spi_link_pkg::WORD_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [WORD_W-1:0] DATA,
  input  logic              ENA,
  input  logic [7:0]        MSG_LEN,
  input  logic              START,
  output logic              FULL,
  output logic              OVERFLOW,
  output logic              BUSY,
  output logic              TX_CLK,
  output logic              TX_DATA,
  output logic              TX_LOAD,
  output logic              TX_STOP
);

`ifdef SPI_SENDER_PARITY_EN
  localparam int FRAME_BITS = WORD_W + 1;
`else
  localparam int FRAME_BITS = WORD_W;
`endif
  localparam int TMR_W = $clog2(2 * CLK_DIV);

  localparam logic [TMR_W-1:0]     TMR_ZERO    = {TMR_W{1'b0}};
  localparam logic [TMR_W-1:0]     TMR_ONE     = TMR_W'(1);
  localparam logic [TMR_W-1:0]     HALF        = TMR_W'(CLK_DIV);
  localparam logic [TMR_W-1:0]     PERIOD_LAST = TMR_W'(2 * CLK_DIV - 1);
  localparam logic [TMR_W-1:0]     GAP_SHORT   = TMR_W'(2 * CLK_DIV - 2);
  localparam logic [BIT_CNT_W-1:0] BIT_ZERO    = {BIT_CNT_W{1'b0}};
  localparam logic [BIT_CNT_W-1:0] BIT_ONE     = BIT_CNT_W'(1);
  localparam logic [BIT_CNT_W-1:0] BIT_LAST    = BIT_CNT_W'(FRAME_BITS - 1);

  link_state_e               state_r, state_nx_s;
  logic [TMR_W-1:0]          tmr_r, tmr_nx_s, gap_last_s;
  logic [BIT_CNT_W-1:0]      bit_r, bit_nx_s;
  logic [FRAME_BITS-1:0]     sh_r, sh_nx_s, frame_s;
  logic [7:0]                words_r, words_nx_s;
  logic                      pop_s;
  logic                      fifo_full_s, fifo_empty_s;
  logic [WORD_W-1:0]         fifo_data_s;
  logic                      tx_clk_r, tx_data_r, tx_load_r, tx_stop_r, busy_r, overflow_r;
  logic                      tx_clk_nx_s, tx_data_nx_s, tx_load_nx_s, tx_stop_nx_s, busy_nx_s;

  spi_sender_fifo #(
    .AW (FIFO_AW),
    .DW (WORD_W)
  ) u_fifo (
    .clk     (CLK),
    .rst     (RST),
    .wr_en   (ENA),
    .wr_data (DATA),
    .rd_en   (pop_s),
    .rd_data (fifo_data_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

`ifdef SPI_SENDER_PARITY_EN
  assign frame_s = {fifo_data_s, odd_parity(fifo_data_s)};
`else
  assign frame_s = fifo_data_s;
`endif

  // Next-state logic; outputs are derived from the next state so they can be registered.
  always_comb begin
    state_nx_s = state_r;
    tmr_nx_s   = tmr_r;
    bit_nx_s   = bit_r;
    sh_nx_s    = sh_r;
    words_nx_s = words_r;
    pop_s      = 1'b0;
    // Mid-message the gap is one cycle short, so GAP plus FETCH keeps the LOAD-low time at 2*CLK_DIV.
    if (words_r == 8'd0) begin
      gap_last_s = PERIOD_LAST;
    end else begin
      gap_last_s = GAP_SHORT;
    end

    case (state_r)
      IDLE: begin
        if (START && (MSG_LEN != 8'd0)) begin
          state_nx_s = FETCH;
          words_nx_s = MSG_LEN;
        end else begin
          state_nx_s = IDLE;
        end
      end
      FETCH, WAIT: begin
        if (!fifo_empty_s) begin
          pop_s      = 1'b1;
          sh_nx_s    = frame_s;
          tmr_nx_s   = TMR_ZERO;
          bit_nx_s   = BIT_ZERO;
          state_nx_s = SHIFT;
        end else begin
          state_nx_s = WAIT;
        end
      end
      SHIFT: begin
        if (tmr_r == PERIOD_LAST) begin
          tmr_nx_s = TMR_ZERO;
          if (bit_r == BIT_LAST) begin
            state_nx_s = GAP;
            words_nx_s = words_r - 8'd1;
          end else begin
            bit_nx_s = bit_r + BIT_ONE;
            sh_nx_s  = {sh_r[FRAME_BITS-2:0], 1'b0};
          end
        end else begin
          tmr_nx_s = tmr_r + TMR_ONE;
        end
      end
      GAP: begin
        if (tmr_r == gap_last_s) begin
          tmr_nx_s = TMR_ZERO;
          if (words_r == 8'd0) begin
            state_nx_s = STOP;
          end else begin
            state_nx_s = FETCH;
          end
        end else begin
          tmr_nx_s = tmr_r + TMR_ONE;
        end
      end
      STOP: begin
        if (tmr_r == PERIOD_LAST) begin
          tmr_nx_s   = TMR_ZERO;
          state_nx_s = IDLE;
        end else begin
          tmr_nx_s = tmr_r + TMR_ONE;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase

    tx_load_nx_s = (state_nx_s == SHIFT);
    tx_clk_nx_s  = tx_load_nx_s && (tmr_nx_s >= HALF);
    tx_data_nx_s = tx_load_nx_s && sh_nx_s[FRAME_BITS-1];
    tx_stop_nx_s = (state_nx_s == STOP);
    busy_nx_s    = (state_nx_s != IDLE);
  end

  // State, counters, shift register and registered link outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r    <= IDLE;
      tmr_r      <= TMR_ZERO;
      bit_r      <= BIT_ZERO;
      sh_r       <= {FRAME_BITS{1'b0}};
      words_r    <= 8'd0;
      tx_clk_r   <= 1'b0;
      tx_data_r  <= 1'b0;
      tx_load_r  <= 1'b0;
      tx_stop_r  <= 1'b0;
      busy_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      tmr_r      <= tmr_nx_s;
      bit_r      <= bit_nx_s;
      sh_r       <= sh_nx_s;
      words_r    <= words_nx_s;
      tx_clk_r   <= tx_clk_nx_s;
      tx_data_r  <= tx_data_nx_s;
      tx_load_r  <= tx_load_nx_s;
      tx_stop_r  <= tx_stop_nx_s;
      busy_r     <= busy_nx_s;
      overflow_r <= overflow_r || (ENA && fifo_full_s);
    end
  end

  assign FULL     = fifo_full_s;
  assign OVERFLOW = overflow_r;
  assign BUSY     = busy_r;
  assign TX_CLK   = tx_clk_r;
  assign TX_DATA  = tx_data_r;
  assign TX_LOAD  = tx_load_r;
  assign TX_STOP  = tx_stop_r;

endmodule

// File: tb/tb_spi_msg_sender.sv
// Scoreboard bench for spi_msg_sender: words pushed are queued and compared as they leave the serial link.
module tb_spi_msg_sender;

  localparam int CLK_DIV = 4;
`ifdef SPI_SENDER_PARITY_EN
  localparam int FRAME = 17;
`else
  localparam int FRAME = 16;
`endif

  logic        CLK = 1'b0;
  logic        RST, ENA, START;
  logic [15:0] DATA;
  logic [7:0]  MSG_LEN;
  logic        FULL, OVERFLOW, BUSY, TX_CLK, TX_DATA, TX_LOAD, TX_STOP;

  int checks_cnt = 0;
  int errors_cnt = 0;

  logic [15:0] sb[$];
  int          gaps_q[$];
  int          cyc = 0, fall_cyc = 0, load_len = 0, nbits = 0;
  int          stop_cnt = 0, stop_len = 0, last_stop_len = 0, stop_gap = 0, words_seen = 0;
  bit          have_fall = 0, prev_load = 0, prev_clk = 0, prev_stop = 0;
  logic [31:0] rx = 32'd0;
  logic [15:0] exp_w;

  spi_msg_sender #(.CLK_DIV(CLK_DIV), .FIFO_AW(8), .WORD_W(16)) dut (
    .CLK(CLK), .RST(RST), .DATA(DATA), .ENA(ENA), .MSG_LEN(MSG_LEN), .START(START),
    .FULL(FULL), .OVERFLOW(OVERFLOW), .BUSY(BUSY), .TX_CLK(TX_CLK), .TX_DATA(TX_DATA),
    .TX_LOAD(TX_LOAD), .TX_STOP(TX_STOP)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Link monitor, sampled on the falling system-clock edge.
  always @(negedge CLK) begin
    cyc++;
    if (RST) begin
      load_len = 0; nbits = 0; rx = 32'd0; stop_len = 0;
      have_fall = 0; prev_load = 0; prev_clk = 0; prev_stop = 0;
    end else begin
      if (TX_LOAD) begin
        if (!prev_load) begin
          load_len = 0; nbits = 0; rx = 32'd0;
          if (have_fall) gaps_q.push_back(cyc - fall_cyc);
        end
        load_len++;
        if (TX_CLK && !prev_clk) begin
          rx = {rx[30:0], TX_DATA};
          nbits++;
        end
      end else if (prev_load) begin
        fall_cyc = cyc; have_fall = 1; words_seen++;
        chk("load_len", load_len, FRAME * 2 * CLK_DIV);
        chk("nbits", nbits, FRAME);
        if (sb.size() == 0) begin
          chk("sb_underflow", sb.size(), 1);
        end else begin
          exp_w = sb.pop_front();
`ifdef SPI_SENDER_PARITY_EN
          chk("word", rx[16:1], exp_w);
          chk("parity", rx[0], ~(^exp_w));
`else
          chk("word", rx[15:0], exp_w);
`endif
        end
      end
      if (TX_STOP) begin
        if (!prev_stop) begin
          stop_cnt++; stop_gap = cyc - fall_cyc; have_fall = 0; stop_len = 0;
        end
        stop_len++;
      end else if (prev_stop) begin
        last_stop_len = stop_len;
        chk("busy_after_stop", BUSY, 0);
      end
      prev_load = TX_LOAD; prev_clk = TX_CLK; prev_stop = TX_STOP;
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic push_word(input logic [15:0] w, input bit accept);
    ENA = 1'b1; DATA = w;
    if (accept) sb.push_back(w);
    tick();
    ENA = 1'b0;
  endtask

  task automatic start_msg(input logic [7:0] len);
    START = 1'b1; MSG_LEN = len;
    tick();
    START = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (BUSY && n < budget) begin
      tick();
      n++;
    end
    chk("idle_timeout", BUSY, 0);
    repeat (2) tick();
  endtask

  task automatic clear_stats();
    gaps_q.delete(); stop_cnt = 0; words_seen = 0; have_fall = 0;
  endtask

  initial begin
    RST = 1'b1; ENA = 1'b0; START = 1'b0; DATA = 16'h0000; MSG_LEN = 8'd0;
    repeat (3) tick();
    chk("reset_outputs", {FULL, OVERFLOW, BUSY, TX_CLK, TX_DATA, TX_LOAD, TX_STOP}, 7'd0);
    RST = 1'b0;
    tick();

    // 1: reset mid-SHIFT, then START on an empty buffer
    clear_stats();
    push_word(16'h1234, 1'b1);
    start_msg(8'd1);
    repeat (30) tick();
    chk("t1_in_shift", TX_LOAD, 1);
    RST = 1'b1;
    tick();
    chk("t1_reset_outputs", {FULL, OVERFLOW, BUSY, TX_CLK, TX_DATA, TX_LOAD, TX_STOP}, 7'd0);
    repeat (2) tick();
    RST = 1'b0;
    sb.delete();
    tick();
    start_msg(8'd1);
    repeat (20) tick();
    chk("t1_wait_busy", BUSY, 1);
    chk("t1_wait_load", TX_LOAD, 0);
    chk("t1_no_stop", stop_cnt, 0);
    push_word(16'h0F0F, 1'b1);
    wait_idle(500);
    chk("t1_words", words_seen, 1);
    chk("t1_stops", stop_cnt, 1);

    // 2: single word A55A, latency and STOP timing
    clear_stats();
    push_word(16'hA55A, 1'b1);
    start_msg(8'd1);
    chk("t2_busy_n1", BUSY, 1);
    chk("t2_load_n1", TX_LOAD, 0);
    tick();
    chk("t2_load_n2", TX_LOAD, 1);
    wait_idle(500);
    chk("t2_stop_gap", stop_gap, 2 * CLK_DIV);
    chk("t2_stop_len", last_stop_len, 2 * CLK_DIV);
    chk("t2_stops", stop_cnt, 1);
    chk("t2_busy_low", BUSY, 0);

    // 3: three words, inter-word gaps, single STOP
    clear_stats();
    push_word(16'h0001, 1'b1);
    push_word(16'h8000, 1'b1);
    push_word(16'hFFFF, 1'b1);
    start_msg(8'd3);
    wait_idle(1000);
    chk("t3_words", words_seen, 3);
    chk("t3_stops", stop_cnt, 1);
    chk("t3_ngaps", gaps_q.size(), 2);
    if (gaps_q.size() == 2) begin
      chk("t3_gap0", gaps_q[0], 2 * CLK_DIV);
      chk("t3_gap1", gaps_q[1], 2 * CLK_DIV);
    end

    // 4: underrun into WAIT, resume two cycles after the push
    clear_stats();
    push_word(16'h1111, 1'b1);
    start_msg(8'd2);
    repeat (500) tick();
    chk("t4_wait_busy", BUSY, 1);
    chk("t4_wait_load", TX_LOAD, 0);
    chk("t4_words_mid", words_seen, 1);
    push_word(16'h2222, 1'b1);
    chk("t4_load_p1", TX_LOAD, 0);
    tick();
    chk("t4_load_p2", TX_LOAD, 1);
    wait_idle(500);
    chk("t4_words", words_seen, 2);
    chk("t4_stops", stop_cnt, 1);

    // 5: fill, overflow, ignored STARTs, full drain
    clear_stats();
    for (int i = 0; i < 256; i++) push_word(16'(i * 16'h0101 + 16'h0037), 1'b1);
    chk("t5_full", FULL, 1);
    chk("t5_no_ovf", OVERFLOW, 0);
    push_word(16'hDEAD, 1'b0);
    chk("t5_ovf", OVERFLOW, 1);
    chk("t5_still_full", FULL, 1);
    start_msg(8'd0);
    repeat (3) tick();
    chk("t5_len0_ignored", BUSY, 0);
    start_msg(8'd255);
    chk("t5_busy", BUSY, 1);
    repeat (50) tick();
    start_msg(8'd5);
    wait_idle(45000);
    chk("t5_words", words_seen, 255);
    chk("t5_stops", stop_cnt, 1);
    chk("t5_left", sb.size(), 1);
    repeat (5) tick();
    chk("t5_busy_start_ignored", BUSY, 0);
    start_msg(8'd1);
    wait_idle(500);
    chk("t5_drained", sb.size(), 0);
    chk("t5_ovf_sticky", OVERFLOW, 1);
    chk("t5_not_full", FULL, 0);

`ifdef SPI_SENDER_PARITY_EN
    // 6: parity bit values (checked in the monitor) and widened word time
    clear_stats();
    push_word(16'h0001, 1'b1);
    push_word(16'h0003, 1'b1);
    start_msg(8'd2);
    wait_idle(1000);
    chk("t6_words", words_seen, 2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
